pipe_stage_skid: RTL and testbench

- Parametrised pipeline-stage register; successor to the fixed 128-bit stall register.
- Adds an explicit valid/ready handshake, a 2-entry skid buffer, a flush input and a configurable width.
- Valid is carried explicitly, not derived from data, so all-zero payloads are legal.
- Sits between processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); stages are chained directly.

---
 rtl/pipe_stage_skid.sv | 86 ++++++++
 tb/tb_pipe_stage_skid.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer, flush and stall
// Optional transfer counter on xfer_cnt when PIPE_STAGE_SKID_XFER_CNT_EN is defined.
module pipe_stage_skid #(
    parameter int               WIDTH      = 128,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stallbar,
    input  logic             Flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_STAGE_SKID_XFER_CNT_EN
    output logic [31:0]      xfer_cnt,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic             accept;
    logic             drain;

    // Handshake outputs come only from registered state and Stallbar, so
    // chained stages never form a combinational ready loop.
    assign in_ready  = Stallbar & (state != TWO);
    assign out_valid = Stallbar & (state != EMPTY);
    assign out_data  = m_data;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= EMPTY;
            m_data <= RESET_DATA;
            s_data <= RESET_DATA;
        end else if (Flush) begin
            state <= EMPTY;
        end else if (Stallbar) begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m_data <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        m_data <= in_data;
                    end else if (accept) begin
                        s_data <= in_data;
                        state  <= TWO;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        m_data <= s_data;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_XFER_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Reset || Flush) begin
            xfer_cnt <= 32'd0;
        end else if (drain) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized check of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

    localparam int W = 128;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Stallbar = 1'b1;
    logic         Flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_SKID_XFER_CNT_EN
    logic [31:0]  xfer_cnt;
`endif

    pipe_stage_skid #(.WIDTH(W), .RESET_DATA('0)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stallbar  (Stallbar),
        .Flush     (Flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_STAGE_SKID_XFER_CNT_EN
        .xfer_cnt  (xfer_cnt),
`endif
        .out_data  (out_data)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: the stage is a FIFO of at most two payloads; the head
    // register keeps the last head value once the FIFO empties.
    logic [W-1:0] q[$];
    logic [W-1:0] m_model = '0;
    logic [31:0]  cnt_model = 32'd0;
    int           n_emitted = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic stb, input logic fl,
                        input logic iv, input logic ordy, input logic [W-1:0] d);
        bit acc;
        bit drn;
        Reset = rst; Stallbar = stb; Flush = fl;
        in_valid = iv; out_ready = ordy; in_data = d;
        #1;
        check("in_ready", W'(in_ready), W'(stb && q.size() < 2));
        check("out_valid", W'(out_valid), W'(stb && q.size() > 0));
        check("out_data", out_data, m_model);
`ifdef PIPE_STAGE_SKID_XFER_CNT_EN
        check("xfer_cnt", W'(xfer_cnt), W'(cnt_model));
`endif
        acc = stb && iv && q.size() < 2;
        drn = stb && ordy && q.size() > 0;
        if (!rst) begin
            q.delete();
            m_model = '0;
            cnt_model = 32'd0;
        end else if (fl) begin
            q.delete();
            cnt_model = 32'd0;
        end else begin
            if (drn) begin
                void'(q.pop_front());
                cnt_model++;
                n_emitted++;
            end
            if (acc) q.push_back(d);
        end
        if (q.size() > 0) m_model = q[0];
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 7) == 0) v = '0;
        return v;
    endfunction

    initial begin
        @(posedge Clk);
        #1;
        // reset for two cycles
        step(0, 1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        // zero payload still reports valid
        step(1, 1, 0, 1, 1, '0);
        step(1, 1, 0, 0, 1, '0);
        // backpressure: fill to TWO, then drain 0xA, 0xB
        step(1, 1, 0, 1, 0, W'(8'hA));
        step(1, 1, 0, 1, 0, W'(8'hB));
        step(1, 1, 0, 1, 0, W'(8'hC));
        step(1, 1, 0, 0, 1, '0);
        step(1, 1, 0, 0, 1, '0);
        step(1, 1, 0, 0, 1, '0);
        // streaming 0..99 with no bubbles
        n_emitted = 0;
        for (int i = 0; i < 100; i++) step(1, 1, 0, 1, 1, W'(i));
        step(1, 1, 0, 0, 1, '0);
        check("stream_count", W'(n_emitted), W'(100));
        // stall while holding 0x5,0x6
        step(1, 1, 0, 1, 0, W'(8'h5));
        step(1, 1, 0, 1, 0, W'(8'h6));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, W'(8'h77));
        step(1, 1, 0, 0, 1, '0);
        step(1, 1, 0, 0, 1, '0);
        step(1, 1, 0, 0, 1, '0);
        // flush while full with downstream ready
        step(1, 1, 0, 1, 1, W'(8'h21));
        step(1, 1, 0, 1, 0, W'(8'h22));
        step(1, 1, 0, 1, 0, W'(8'h23));
        step(1, 1, 1, 1, 1, W'(8'h24));
        step(1, 1, 0, 0, 1, '0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 rnd_data());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
